// File: rtl/reed_solomon_job_ctrl.sv
// reed_solomon_job_ctrl
// Job sequencer for the Reed-Solomon decoder AFU. Decodes host MMIO writes
// into the DSM base, control word and buffer descriptors, launches the read
// engine (descriptor 0) and write engine (descriptor 1), waits for both
// engines to finish, then posts one completion record to the DSM line.
//
// Optional feature: define RS_JOB_CYCLE_COUNT_EN to build the S_RUN cycle
// counter and report it in dsm_data[63:32]. Without it that field reads 0.
module reed_solomon_job_ctrl #(
    parameter int HC_BUFFER_SIZE = 2,
    parameter int CL_ADDR_W      = 42
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mmio_wr_valid,
    input  logic [15:0]          mmio_wr_addr,
    input  logic [63:0]          mmio_wr_data,
    output logic                 rd_start,
    output logic                 wr_start,
    output logic [CL_ADDR_W-1:0] rd_addr,
    output logic [CL_ADDR_W-1:0] wr_addr,
    output logic [31:0]          rd_size,
    output logic [31:0]          wr_size,
    input  logic                 rd_done,
    input  logic                 wr_done,
    output logic                 engine_rst,
    output logic                 dsm_wr_valid,
    input  logic                 dsm_wr_ready,
    output logic [CL_ADDR_W-1:0] dsm_addr,
    output logic [63:0]          dsm_data,
    output logic                 busy
);

    localparam logic [15:0] ADDR_DSM   = 16'h0110;
    localparam logic [15:0] ADDR_CTRL  = 16'h0118;
    localparam logic [15:0] ADDR_DESC0 = 16'h0120;

    localparam logic [1:0] STATUS_DONE = 2'h1;
    localparam logic [1:0] STATUS_STOP = 2'h2;

    typedef enum logic [1:0] {
        S_RESET,
        S_IDLE,
        S_RUN,
        S_REPORT
    } state_t;

    state_t state;
    state_t state_next;

    logic [CL_ADDR_W-1:0] desc_addr [HC_BUFFER_SIZE];
    logic [31:0]          desc_size [HC_BUFFER_SIZE];
    logic [CL_ADDR_W-1:0] dsm_addr_q;
    logic                 rd_flag;
    logic                 wr_flag;
    logic [1:0]           status_q;
    logic                 start_q;
    logic                 stop_q;
    logic [31:0]          cycle_count;

    logic ctrl_wr;
    logic cmd_reset;
    logic cmd_release;
    logic cmd_start;
    logic cmd_stop;
    logic cfg_wr;
    logic launch;
    logic finish_ok;
    logic finish_stop;
    logic rd_seen;
    logic wr_seen;

    // Control word decode; only the exact codes act, anything else is ignored.
    assign ctrl_wr     = mmio_wr_valid && (mmio_wr_addr == ADDR_CTRL);
    assign cmd_reset   = ctrl_wr && (mmio_wr_data == 64'h0);
    assign cmd_release = ctrl_wr && (mmio_wr_data == 64'h1);
    assign cmd_start   = ctrl_wr && (mmio_wr_data == 64'h3);
    assign cmd_stop    = ctrl_wr && (mmio_wr_data == 64'h7);

    // Configuration registers are frozen while a job is in flight.
    assign cfg_wr = mmio_wr_valid && ((state == S_RESET) || (state == S_IDLE));

    // A done pulse in the same cycle as the flag check counts immediately,
    // so the final done at cycle N moves to S_REPORT at N+1.
    assign rd_seen = rd_flag || rd_done;
    assign wr_seen = wr_flag || wr_done;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RESET;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic, transition strobes and state-decoded outputs.
    always_comb begin
        state_next   = state;
        launch       = 1'b0;
        finish_ok    = 1'b0;
        finish_stop  = 1'b0;
        busy         = 1'b0;
        dsm_wr_valid = 1'b0;
        engine_rst   = stop_q;
        dsm_data     = 64'h0;
        if (cmd_reset) begin
            state_next = S_RESET;
        end else begin
            case (state)
                S_RESET: begin
                    if (cmd_release) state_next = S_IDLE;
                end
                S_IDLE: begin
                    if (cmd_start) begin
                        state_next = S_RUN;
                        launch     = 1'b1;
                    end
                end
                S_RUN: begin
                    if (rd_seen && wr_seen) begin
                        state_next = S_REPORT;
                        finish_ok  = 1'b1;
                    end else if (cmd_stop) begin
                        state_next  = S_REPORT;
                        finish_stop = 1'b1;
                    end
                end
                S_REPORT: begin
                    if (dsm_wr_ready) state_next = S_IDLE;
                end
                default: state_next = S_RESET;
            endcase
        end
        case (state)
            S_RESET: engine_rst = 1'b1;
            S_RUN:   busy = 1'b1;
            S_REPORT: begin
                busy         = 1'b1;
                dsm_wr_valid = 1'b1;
                dsm_data     = {cycle_count, 30'b0, status_q};
            end
            default: ;
        endcase
    end

    // Descriptor and DSM base registers, written only outside a job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HC_BUFFER_SIZE; i++) begin
                desc_addr[i] <= '0;
                desc_size[i] <= '0;
            end
            dsm_addr_q <= '0;
        end else if (cfg_wr) begin
            if (mmio_wr_addr == ADDR_DSM) begin
                dsm_addr_q <= mmio_wr_data[CL_ADDR_W-1:0];
            end
            for (int i = 0; i < HC_BUFFER_SIZE; i++) begin
                if (mmio_wr_addr == ADDR_DESC0 + 16'(16 * i)) begin
                    desc_addr[i] <= mmio_wr_data[CL_ADDR_W-1:0];
                end
                if (mmio_wr_addr == ADDR_DESC0 + 16'(16 * i) + 16'h8) begin
                    desc_size[i] <= mmio_wr_data[31:0];
                end
            end
        end
    end

    // Job bookkeeping: sticky done flags, completion status, launch/stop pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_flag  <= 1'b0;
            wr_flag  <= 1'b0;
            status_q <= 2'h0;
            start_q  <= 1'b0;
            stop_q   <= 1'b0;
        end else begin
            start_q <= launch;
            stop_q  <= finish_stop;
            if (cmd_reset || launch) begin
                rd_flag <= 1'b0;
                wr_flag <= 1'b0;
            end else if (state == S_RUN) begin
                if (rd_done) rd_flag <= 1'b1;
                if (wr_done) wr_flag <= 1'b1;
            end
            if (cmd_reset) begin
                status_q <= 2'h0;
            end else if (finish_ok) begin
                status_q <= STATUS_DONE;
            end else if (finish_stop) begin
                status_q <= STATUS_STOP;
            end
        end
    end

`ifdef RS_JOB_CYCLE_COUNT_EN
    // Saturating count of cycles spent in S_RUN for the completion record.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count <= 32'h0;
        end else if (cmd_reset || launch) begin
            cycle_count <= 32'h0;
        end else if ((state == S_RUN) && (cycle_count != 32'hFFFF_FFFF)) begin
            cycle_count <= cycle_count + 32'h1;
        end
    end
`else
    assign cycle_count = 32'h0;
`endif

    assign rd_start = start_q;
    assign wr_start = start_q;
    assign rd_addr  = desc_addr[0];
    assign wr_addr  = desc_addr[1];
    assign rd_size  = desc_size[0];
    assign wr_size  = desc_size[1];
    assign dsm_addr = dsm_addr_q;

endmodule
